// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, prefix constants and key table for the PS/2 key decoder
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  localparam int KEYS_PER_PLAYER = 5;
  localparam int MAX_KEYS        = 10;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_code_t;

  // Index = player*5 + {up, down, left, right, reset}
  localparam key_code_t KEY_TABLE [MAX_KEYS] = '{
    '{1'b0, 8'h1D}, '{1'b0, 8'h1B}, '{1'b0, 8'h1C}, '{1'b0, 8'h23}, '{1'b0, 8'h29},
    '{1'b1, 8'h75}, '{1'b1, 8'h72}, '{1'b1, 8'h6B}, '{1'b1, 8'h74}, '{1'b0, 8'h5A}
  };

  function automatic logic frame_good(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser, stability filter and falling-edge pulse for one PS/2 line
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The filtered level only moves after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        filt <= sync[1];
        fall <= filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver with E0/F0 prefix resolution and per-key held levels
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter  int NUM_PLAYERS = 2,
  parameter  int FILT_LEN    = 8,
  parameter  int TIMEOUT_CYC = 200_000,
  localparam int NUM_KEYS    = KEYS_PER_PLAYER * NUM_PLAYERS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kclk,
  input  logic                kdata,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                scan_valid,
  output logic [7:0]          scan_code,
  output logic                scan_ext,
  output logic                scan_brk,
  output logic                frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic bit_ev, dat, clk_filt_unused, data_fall_unused;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .raw(kclk), .filt(clk_filt_unused), .fall(bit_ev)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
    .clk(clk), .reset(reset), .raw(kdata), .filt(dat), .fall(data_fall_unused)
  );

  rx_state_t           state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [7:0]          sh, sh_n;
  logic                par, par_n;
  logic                ext, ext_n, brk, brk_n;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [NUM_KEYS-1:0] key_n;
  logic                scan_valid_n, scan_ext_n, scan_brk_n, frame_err_n;
  logic [7:0]          scan_code_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      tcnt       <= '0;
      key_state  <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      scan_ext   <= 1'b0;
      scan_brk   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      par        <= par_n;
      ext        <= ext_n;
      brk        <= brk_n;
      tcnt       <= tcnt_n;
      key_state  <= key_n;
      scan_valid <= scan_valid_n;
      scan_code  <= scan_code_n;
      scan_ext   <= scan_ext_n;
      scan_brk   <= scan_brk_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sh_n         = sh;
    par_n        = par;
    ext_n        = ext;
    brk_n        = brk;
    key_n        = key_state;
    scan_valid_n = 1'b0;
    scan_code_n  = scan_code;
    scan_ext_n   = scan_ext;
    scan_brk_n   = scan_brk;
    frame_err_n  = 1'b0;

    if (state == IDLE || bit_ev)
      tcnt_n = '0;
    else if (tcnt != TW'(TIMEOUT_CYC))
      tcnt_n = tcnt + 1'b1;
    else
      tcnt_n = tcnt;

    case (state)
      IDLE: begin
        if (bit_ev && !dat) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (bit_ev) begin
          sh_n  = {dat, sh[7:1]};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (bit_ev) begin
          par_n   = dat;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_ev) begin
          state_n = IDLE;
          if (!frame_good(sh, par, dat)) begin
            frame_err_n = 1'b1;
            ext_n       = 1'b0;
            brk_n       = 1'b0;
          end else if (sh == PS2_E0) begin
            ext_n = 1'b1;
          end else if (sh == PS2_F0) begin
            brk_n = 1'b1;
          end else begin
            scan_valid_n = 1'b1;
            scan_code_n  = sh;
            scan_ext_n   = ext;
            scan_brk_n   = brk;
            ext_n        = 1'b0;
            brk_n        = 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
              if (KEY_TABLE[k].ext == ext && KEY_TABLE[k].code == sh)
                key_n[k] = ~brk;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled partial frame is abandoned; a bit event in the same cycle wins.
    if (state != IDLE && !bit_ev && tcnt >= TW'(TIMEOUT_CYC - 1)) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
      ext_n       = 1'b0;
      brk_n       = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed and randomized PS/2 frames checked against a byte-level key model
module tb_ps2_key_decoder;

  localparam int NK = 10;
  localparam int FL = 8;
  localparam int TO = 200;
  localparam int H  = 20;

  logic clk = 1'b0;
  logic reset, kclk, kdata;
  logic [NK-1:0] key_state;
  logic scan_valid, scan_ext, scan_brk, frame_err;
  logic [7:0] scan_code;

  always #5 clk = ~clk;

  ps2_key_decoder #(.NUM_PLAYERS(2), .FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .kclk(kclk), .kdata(kdata),
    .key_state(key_state), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_ext(scan_ext), .scan_brk(scan_brk), .frame_err(frame_err)
  );

  int vectors = 0;
  int miscompares = 0;

  int sv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] last_code = '0;
  logic last_ext = 1'b0, last_brk = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (scan_valid) begin
        sv_cnt    <= sv_cnt + 1;
        last_code <= scan_code;
        last_ext  <= scan_ext;
        last_brk  <= scan_brk;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
    end
  end

  logic [7:0] t_code [NK] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
  bit         t_ext  [NK] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  logic [7:0] pool   [16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B,
                              8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE};

  logic [NK-1:0] exp_key = '0;
  int exp_sv = 0, exp_fe = 0;
  logic [7:0] exp_code = '0;
  logic exp_ext = 1'b0, exp_brk = 1'b0;
  logic m_ext = 1'b0, m_brk = 1'b0;

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_fe++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_sv++;
      exp_code = b;
      exp_ext  = m_ext;
      exp_brk  = m_brk;
      for (int k = 0; k < NK; k++)
        if (t_code[k] == b && t_ext[k] == m_ext) exp_key[k] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " strobes"}, sv_cnt, exp_sv);
    chk({tag, " frame_err"}, fe_cnt, exp_fe);
    chk({tag, " key_state"}, 32'(key_state), 32'(exp_key));
    if (exp_sv > 0) begin
      chk({tag, " scan_code"}, 32'(last_code), 32'(exp_code));
      chk({tag, " scan_ext/brk"}, {30'd0, last_ext, last_brk}, {30'd0, exp_ext, exp_brk});
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    kdata = b;
    if (glitch) begin
      wait_cyc(H / 2); kclk = 1'b0; wait_cyc(1); kclk = 1'b1; wait_cyc(H - H / 2 - 1);
    end else wait_cyc(H);
    kclk = 1'b0;
    if (glitch) begin
      wait_cyc(H / 2); kclk = 1'b1; wait_cyc(1); kclk = 1'b0; wait_cyc(H - H / 2 - 1);
    end else wait_cyc(H);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
    send_bit(~bad_stop, glitch);
    kdata = 1'b1;
    wait_cyc(H);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  initial begin
    logic [7:0] b;
    bit bp, bs;
    reset = 1'b1; kclk = 1'b1; kdata = 1'b1;
    wait_cyc(3);
    chk("reset outputs", {18'd0, key_state, scan_valid, scan_code, scan_ext, scan_brk, frame_err}, 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    send_frame(8'h1D, 0, 0, 0);
    check_all("t1 make W");

    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1D, 0, 0, 0);
    check_all("t2 break W");

    send_frame(8'hE0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    check_all("t3 make up");
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    check_all("t3 break up");
    send_frame(8'h75, 0, 0, 0);
    check_all("t3 plain 75");

    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h1B, 0, 1, 0);
    check_all("t4 bad frames");

    b = 8'h5A;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(b[i], 0);
    kdata = 1'b1;
    wait_cyc(TO + 1 + 40);
    model_byte(8'h00, 0);
    check_all("t5 timeout");
    send_frame(8'h23, 0, 0, 0);
    check_all("t5 after timeout");

    send_frame(8'h1B, 0, 0, 1);
    check_all("t6 glitched frame");
    send_frame(8'h29, 0, 0, 0);
    check_all("t6 make space");
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    reset = 1'b1;
    wait_cyc(1);
    chk("t6 reset outputs", {18'd0, key_state, scan_valid, scan_code, scan_ext, scan_brk, frame_err}, 32'd0);
    reset = 1'b0;
    kdata = 1'b1;
    exp_key = '0; m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(20);
    check_all("t6 after reset");
    send_frame(8'h29, 0, 0, 0);
    check_all("t6 space again");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 15)];
      bp = ($urandom_range(0, 11) == 0);
      bs = !bp && ($urandom_range(0, 11) == 0);
      send_frame(b, bp, bs, $urandom_range(0, 3) == 0);
      check_all($sformatf("rand %0d byte %h", n, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
